rc4_key_search_ctrl: RTL and testbench

RC4_KEY_SEARCH_CTRL -- requirements
Module: rc4_key_search_ctrl

---
 rtl/rc4_key_search_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rc4_key_search_ctrl
//  Brief    : Hands RC4 candidate keys to a pool of decryption cores, collects
//             their completions and stops on the first key whose decrypted
//             message passes the check, or when the key space is exhausted.
//  Options  : define RC4_KS_PROGRESS_EN to build the keys_tested counter;
//             without it keys_tested is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module rc4_key_search_ctrl #(
  parameter int              NUM_CORES = 2,
  parameter int              KEY_W     = 22,
  parameter logic [KEY_W-1:0] KEY_MAX  = {KEY_W{1'b1}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic                       core_abort,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_valid,
  output logic                       busy,
  output logic                       found,
  output logic [KEY_W-1:0]           found_key,
  output logic                       exhausted,
  output logic [KEY_W:0]             keys_tested
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_FOUND     = 2'd2,
    ST_EXHAUSTED = 2'd3
  } state_t;

  // One bit wider than a key so the final increment past KEY_MAX never wraps.
  localparam logic [KEY_W:0] c_KEY_LAST = {1'b0, KEY_MAX};

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [KEY_W:0]             r_next_key;
  logic [NUM_CORES-1:0]       r_core_busy;
  logic [NUM_CORES-1:0]       r_core_start;
  logic [NUM_CORES*KEY_W-1:0] r_core_key;
  logic                       r_core_abort;
  logic [KEY_W-1:0]           r_found_key;

  logic                       w_in_run;
  logic [NUM_CORES-1:0]       w_done_vec;
  logic [NUM_CORES-1:0]       w_valid_vec;
  logic                       w_any_valid;
  logic [NUM_CORES-1:0]       w_win_oh;
  logic [NUM_CORES-1:0]       w_idle_vec;
  logic [NUM_CORES-1:0]       w_disp_oh;
  logic [NUM_CORES-1:0]       w_busy_after;
  logic                       w_keys_left;
  logic                       w_dispatch;
  logic [KEY_W-1:0]           w_win_key;

  // Completions only count in RUN and only from cores that hold a key.
  assign w_in_run     = (r_state == ST_RUN);
  assign w_done_vec   = w_in_run ? (core_done & r_core_busy) : '0;
  assign w_valid_vec  = w_done_vec & core_valid;
  assign w_any_valid  = |w_valid_vec;
  // Isolating the lowest set bit gives the lowest-index winner / idle core.
  assign w_win_oh     = w_valid_vec & (~w_valid_vec + NUM_CORES'(1));
  assign w_idle_vec   = ~r_core_busy;
  assign w_disp_oh    = w_idle_vec & (~w_idle_vec + NUM_CORES'(1));
  assign w_busy_after = r_core_busy & ~w_done_vec;
  assign w_keys_left  = (r_next_key <= c_KEY_LAST);
  // A valid completion pre-empts dispatch in the same cycle.
  assign w_dispatch   = w_in_run && !w_any_valid && (|w_idle_vec) && w_keys_left;

  // Select the key held by the winning core.
  always_comb begin
    w_win_key = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_win_oh[i]) begin
        w_win_key = r_core_key[i*KEY_W +: KEY_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_any_valid) begin
          w_state_nxt = ST_FOUND;
        end else if (!w_keys_left && (r_core_busy == '0)) begin
          w_state_nxt = ST_EXHAUSTED;
        end
      end
      default: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end
      end
    endcase
  end

  // Key pointer, core occupancy, launch/abort pulses and the winning key.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_next_key   <= '0;
      r_core_busy  <= '0;
      r_core_start <= '0;
      r_core_abort <= 1'b0;
      r_found_key  <= '0;
    end else begin
      r_core_start <= '0;
      r_core_abort <= 1'b0;
      if (!w_in_run) begin
        if (start) begin
          r_next_key  <= '0;
          r_core_busy <= '0;
          r_found_key <= '0;
        end
      end else if (w_any_valid) begin
        r_found_key  <= w_win_key;
        r_core_abort <= 1'b1;
        r_core_busy  <= '0;
      end else if (w_dispatch) begin
        r_core_busy  <= w_busy_after | w_disp_oh;
        r_core_start <= w_disp_oh;
        r_next_key   <= r_next_key + (KEY_W+1)'(1);
      end else begin
        r_core_busy  <= w_busy_after;
      end
    end
  end

  // Per-core key slices; a slice only changes when its core is launched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_core_key <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_dispatch && w_disp_oh[i]) begin
          r_core_key[i*KEY_W +: KEY_W] <= r_next_key[KEY_W-1:0];
        end
      end
    end
  end

`ifdef RC4_KS_PROGRESS_EN
  logic [KEY_W:0] r_keys_tested;
  logic [KEY_W:0] w_done_cnt;

  // Several cores may finish in one cycle, so add the number of completions.
  always_comb begin
    w_done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_done_cnt = w_done_cnt + (KEY_W+1)'(w_done_vec[i]);
    end
  end

  // Progress counter, cleared when a new search begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_keys_tested <= '0;
    end else if (!w_in_run) begin
      if (start) begin
        r_keys_tested <= '0;
      end
    end else begin
      r_keys_tested <= r_keys_tested + w_done_cnt;
    end
  end

  assign keys_tested = r_keys_tested;
`else
  assign keys_tested = '0;
`endif

  assign core_start = r_core_start;
  assign core_key   = r_core_key;
  assign core_abort = r_core_abort;
  assign found_key  = r_found_key;
  assign busy       = (r_state == ST_RUN);
  assign found      = (r_state == ST_FOUND);
  assign exhausted  = (r_state == ST_EXHAUSTED);

endmodule
`default_nettype wire

// File: tb/tb_rc4_key_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rc4_key_search_ctrl
//  Brief    : Scoreboard bench for rc4_key_search_ctrl with a randomised
//             latency core model (4 cores, 10-bit keys, full key space).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rc4_key_search_ctrl;

  localparam int NC   = 4;
  localparam int KW   = 10;
  localparam int KMAX = 1023;
`ifdef RC4_KS_PROGRESS_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [NC-1:0]    core_start;
  logic [NC*KW-1:0] core_key;
  logic             core_abort;
  logic [NC-1:0]    core_done;
  logic [NC-1:0]    core_valid;
  logic             busy;
  logic             found;
  logic [KW-1:0]    found_key;
  logic             exhausted;
  logic [KW:0]      keys_tested;

  logic [NC-1:0]    dir_done   = '0;
  logic [NC-1:0]    dir_valid  = '0;
  logic [NC-1:0]    resp_done  = '0;
  logic [NC-1:0]    resp_valid = '0;

  assign core_done  = resp_done  | dir_done;
  assign core_valid = resp_valid | dir_valid;

  int n_vec    = 0;
  int n_err    = 0;
  int exp_q[$];
  int n_starts = 0;
  int n_abort  = 0;
  int resp_cnt = 0;
  bit resp_en  = 1'b0;
  int target   = -1;

  int r_key  [NC];
  int r_cnt  [NC];
  bit r_act  [NC];
  bit r_prev [NC];
  bit found_d = 1'b0;

  rc4_key_search_ctrl #(
    .NUM_CORES (NC),
    .KEY_W     (KW),
    .KEY_MAX   (10'd1023)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .core_start  (core_start),
    .core_key    (core_key),
    .core_abort  (core_abort),
    .core_done   (core_done),
    .core_valid  (core_valid),
    .busy        (busy),
    .found       (found),
    .found_key   (found_key),
    .exhausted   (exhausted),
    .keys_tested (keys_tested)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int key_of(input int i);
    return int'(core_key[i*KW +: KW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // A fresh search must hand out every key 0..KMAX exactly once, in order.
  task automatic push_all();
    for (int k = 0; k <= KMAX; k++) exp_q.push_back(k);
  endtask

  // Monitor: every launch pops the next expected key.
  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (core_start[i]) begin
        n_starts++;
        if (exp_q.size() == 0) check("unexpected_core_start", key_of(i), -1);
        else                   check("core_key_order", key_of(i), exp_q.pop_front());
      end
    end
    if (core_abort) n_abort++;
    if (found && !found_d) exp_q.delete();
    found_d = found;
  end

  // Core model: random latency, reports valid only for the target key.
  always @(negedge clk) begin
    resp_done  = '0;
    resp_valid = '0;
    if (reset) begin
      for (int i = 0; i < NC; i++) r_act[i] = 1'b0;
    end else begin
      r_prev = r_act;
      if (core_abort) for (int i = 0; i < NC; i++) r_act[i] = 1'b0;
      for (int i = 0; i < NC; i++) begin
        if (r_act[i] && resp_en) begin
          if (r_cnt[i] == 0) begin
            check("core_key_stable", key_of(i), r_key[i]);
            resp_done[i]  = 1'b1;
            resp_valid[i] = (r_key[i] == target);
            r_act[i]      = 1'b0;
            resp_cnt++;
          end else begin
            r_cnt[i]--;
          end
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          check("start_on_idle_core", longint'(r_prev[i]), 0);
          r_act[i] = 1'b1;
          r_key[i] = key_of(i);
          r_cnt[i] = int'($urandom_range(0, 6));
        end
      end
      if (resp_en) begin
        for (int i = 0; i < NC; i++) begin
          if (!r_act[i] && !resp_done[i]) begin
            if ($urandom_range(0, 7) == 0) begin
              resp_done[i]  = 1'b1;   // stray completion from an idle core
              resp_valid[i] = 1'b1;
            end else begin
              resp_valid[i] = 1'($urandom_range(0, 1));
            end
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int base_abort;
    int base_starts;
    int base_cnt;

    // Reset state
    repeat (3) tick();
    check("rst_core_start", core_start, 0);
    check("rst_core_abort", core_abort, 0);
    check("rst_busy", busy, 0);
    check("rst_found", found, 0);
    check("rst_exhausted", exhausted, 0);
    check("rst_found_key", found_key, 0);
    check("rst_core_key", core_key, 0);
    check("rst_keys_tested", keys_tested, 0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a search with three cores busy
    push_all();
    start = 1'b1; tick(); start = 1'b0;
    check("busy_in_run", busy, 1);
    cnt = 0;
    for (int c = 0; c < 50 && cnt < 3; c++) begin
      tick();
      cnt += $countones(core_start);
    end
    check("three_dispatched", cnt, 3);
    base_abort = n_abort;
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("midrst_busy", busy, 0);
    check("midrst_core_start", core_start, 0);
    check("midrst_core_abort", core_abort, 0);
    check("midrst_core_key", core_key, 0);
    check("midrst_keys_tested", keys_tested, 0);
    check("midrst_found", found, 0);
    check("midrst_exhausted", exhausted, 0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("midrst_no_abort", n_abort - base_abort, 0);

    // Restart from 0; cores 1 and 3 report valid together
    push_all();
    start = 1'b1; tick(); start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 50 && cnt < 4; c++) begin
      tick();
      cnt += $countones(core_start);
    end
    check("four_dispatched", cnt, 4);
    for (int i = 0; i < NC; i++) check("lowest_idle_core_key", key_of(i), i);
    base_abort = n_abort;
    dir_done  = 4'b1011;
    dir_valid = 4'b1010;
    tick();
    dir_done  = '0;
    dir_valid = '0;
    check("dual_found", found, 1);
    check("dual_found_key", found_key, 1);
    check("dual_abort_pulse", core_abort, 1);
    check("dual_busy", busy, 0);
    check("dual_keys_tested", keys_tested, PROG ? 3 : 0);
    tick();
    check("dual_abort_one_cycle", core_abort, 0);
    base_starts = n_starts;
    repeat (10) tick();
    check("dual_no_start_after_found", n_starts - base_starts, 0);
    check("dual_abort_count", n_abort - base_abort, 1);

    // Full key space, no valid key, start pulsed mid-run
    target      = -1;
    resp_en     = 1'b1;
    base_starts = n_starts;
    push_all();
    start = 1'b1; tick(); start = 1'b0;
    repeat (50) tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 20000 && !exhausted; c++) tick();
    check("exh_exhausted", exhausted, 1);
    check("exh_busy", busy, 0);
    check("exh_found", found, 0);
    check("exh_keys_left", exp_q.size(), 0);
    check("exh_launch_count", n_starts - base_starts, KMAX + 1);
    check("exh_keys_tested", keys_tested, PROG ? KMAX + 1 : 0);

    // Restart from EXHAUSTED; core holding 0x249 reports valid
    target      = 'h249;
    base_starts = n_starts;
    base_abort  = n_abort;
    base_cnt    = resp_cnt;
    push_all();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 20000 && !found; c++) tick();
    check("hit_found", found, 1);
    check("hit_found_key", found_key, 'h249);
    check("hit_busy", busy, 0);
    check("hit_exhausted", exhausted, 0);
    base_starts = n_starts;
    repeat (10) tick();
    check("hit_no_start_after_found", n_starts - base_starts, 0);
    check("hit_abort_count", n_abort - base_abort, 1);
    check("hit_keys_tested", keys_tested, PROG ? resp_cnt - base_cnt : 0);
    resp_en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
